add_normalize: RTL and testbench

ADD_NORMALIZE -- requirements
Module: add_normalize

---
 rtl/add_normalize.sv | 108 ++++++++++
 tb/tb_add_normalize.sv | 125 ++++++++++++
 2 files changed

// File: rtl/add_normalize.sv
// add_normalize: adds or subtracts aligned significands, then normalizes one bit per cycle.
// FSM is IDLE -> ADD -> NORM* -> DONE. ADD takes two cycles: one forms the sum, one classifies it.
module add_normalize (
    input  logic        clk,
    input  logic        rst,
    input  logic        SA,
    input  logic        SB,
    input  logic        C,
    input  logic [7:0]  E,
    input  logic [27:0] A,
    input  logic [27:0] B,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [7:0]  out_exp,
    output logic [27:0] out_mant,
    output logic        out_zero,
    output logic        out_ovf
);
    localparam logic [1:0] IDLE = 2'd0, ADD = 2'd1, NORM = 2'd2, DONE = 2'd3;
    logic [1:0]  st;
    logic        ph, sa_q, sb_q, c_q, sgn;
    logic [7:0]  e_q;
    logic [27:0] a_q, b_q, m, sum, m_sh;
    logic        go, r_sign, r_zero, r_ovf;
    logic [7:0]  r_exp;
    logic [27:0] r_mant;
    assign in_ready  = st == IDLE;
    assign out_valid = st == DONE;
    assign sum  = (sa_q == sb_q) ? a_q + b_q : c_q ? a_q - b_q : b_q - a_q;
    assign m_sh = {m[26:0], 1'b0};
    always_comb begin
        go = 1'b0;
        r_sign = sgn;
        r_exp = e_q;
        r_mant = m;
        r_zero = 1'b0;
        r_ovf = 1'b0;
        if (st == ADD && ph) begin
            if (m[27]) begin
                go = 1'b1;
                r_ovf = e_q == 8'd254;
                r_exp = r_ovf ? 8'd255 : e_q + 8'd1;
                r_mant = r_ovf ? 28'd0 : {1'b0, m[27:2], m[1] | m[0]};
            end else if (m == 28'd0) begin
                go = 1'b1;
                r_sign = 1'b0;
                r_exp = 8'd0;
                r_zero = 1'b1;
            end else if (m[26]) begin
                go = 1'b1;
            end else if (e_q == 8'd1) begin
                go = 1'b1;
                r_exp = 8'd0;
            end
        end else if (st == NORM) begin
            go = e_q == 8'd1 || m_sh[26];
            r_exp = e_q == 8'd1 ? 8'd0 : e_q - 8'd1;
            r_mant = e_q == 8'd1 ? m : m_sh;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            ph <= 1'b0;
            out_sign <= 1'b0;
            out_exp <= 8'd0;
            out_mant <= 28'd0;
            out_zero <= 1'b0;
            out_ovf <= 1'b0;
        end else begin
            case (st)
                IDLE: if (in_valid) begin
                    sa_q <= SA;
                    sb_q <= SB;
                    c_q <= C;
                    e_q <= E;
                    a_q <= A;
                    b_q <= B;
                    ph <= 1'b0;
                    st <= ADD;
                end
                ADD: if (!ph) begin
                    m <= sum;
                    sgn <= (sa_q == sb_q || c_q) ? sa_q : sb_q;
                    ph <= 1'b1;
                end else if (!go) begin
                    st <= NORM;
                end
                NORM: if (e_q != 8'd1) begin
                    m <= m_sh;
                    e_q <= e_q - 8'd1;
                end
                default: if (out_ready) st <= IDLE;
            endcase
            if (go) begin
                st <= DONE;
                out_sign <= r_sign;
                out_exp <= r_exp;
                out_mant <= r_mant;
                out_zero <= r_zero;
                out_ovf <= r_ovf;
            end
        end
    end
endmodule

// File: tb/tb_add_normalize.sv
// tb_add_normalize: directed scoreboard bench for add_normalize.
module tb_add_normalize;
    typedef struct packed {
        logic        s;
        logic [7:0]  e;
        logic [27:0] m;
        logic        z;
        logic        o;
        logic [5:0]  lat;
    } exp_t;
    logic clk = 0, rst = 1, sa = 0, sb = 0, c = 0, in_valid = 0, out_ready = 0;
    logic [7:0] e = 0;
    logic [27:0] a = 0, b = 0;
    logic in_ready, out_valid, out_sign, out_zero, out_ovf;
    logic [7:0] out_exp;
    logic [27:0] out_mant;
    int checks = 0, errors = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    add_normalize dut (
        .clk(clk), .rst(rst), .SA(sa), .SB(sb), .C(c), .E(e), .A(a), .B(b),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant), .out_zero(out_zero), .out_ovf(out_ovf)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, want);
        end
    endtask
    task automatic issue(input logic xsa, xsb, xc, input logic [7:0] xe, input logic [27:0] xa, xb, input exp_t x);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 1);
        sa = xsa; sb = xsb; c = xc; e = xe; a = xa; b = xb; in_valid = 1;
        q.push_back(x);
        @(posedge clk); #1;
        in_valid = 0;
        chk("in_ready_busy", {31'd0, in_ready}, 0);
    endtask
    task automatic collect(input string tag);
        int n = 0;
        exp_t x;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        x = q.pop_front();
        chk({tag, "_lat"}, n, {26'd0, x.lat});
        chk({tag, "_sign"}, {31'd0, out_sign}, {31'd0, x.s});
        chk({tag, "_exp"}, {24'd0, out_exp}, {24'd0, x.e});
        chk({tag, "_mant"}, {4'd0, out_mant}, {4'd0, x.m});
        chk({tag, "_zero"}, {31'd0, out_zero}, {31'd0, x.z});
        chk({tag, "_ovf"}, {31'd0, out_ovf}, {31'd0, x.o});
    endtask
    task automatic retire(input logic [27:0] m_hold);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("retire_valid", {31'd0, out_valid}, 0);
        chk("retire_ready", {31'd0, in_ready}, 1);
        chk("retire_hold", {4'd0, out_mant}, {4'd0, m_hold});
    endtask
    initial begin
        int hits;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_outs", {out_sign, out_zero, out_ovf, out_exp, out_mant[20:0]}, 0);
        chk("rst_mant", {4'd0, out_mant}, 0);
        rst = 0;
        issue(0, 0, 0, 8'd127, 28'h4000000, 28'h4000000, '{0, 8'd128, 28'h4000000, 0, 0, 6'd2});
        collect("carry");
        retire(28'h4000000);
        issue(0, 1, 1, 8'd127, 28'h6000000, 28'h4000000, '{0, 8'd126, 28'h4000000, 0, 0, 6'd3});
        collect("sub1");
        retire(28'h4000000);
        issue(0, 1, 0, 8'd127, 28'h4000000, 28'h6000000, '{1, 8'd126, 28'h4000000, 0, 0, 6'd3});
        collect("swap");
        retire(28'h4000000);
        issue(1, 0, 1, 8'd127, 28'h4000000, 28'h4000000, '{0, 8'd0, 28'h0, 1, 0, 6'd2});
        collect("cancel");
        retire(28'h0);
        issue(0, 0, 1, 8'd254, 28'h4000000, 28'h4000000, '{0, 8'd255, 28'h0, 0, 1, 6'd2});
        collect("ovf");
        retire(28'h0);
        issue(0, 1, 1, 8'd127, 28'h4000000, 28'h3FFFFFF, '{0, 8'd101, 28'h4000000, 0, 0, 6'd28});
        collect("long");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", {31'd0, out_valid}, 1);
            chk("bp_exp", {24'd0, out_exp}, 101);
            chk("bp_mant", {4'd0, out_mant}, 28'h4000000);
        end
        retire(28'h4000000);
        issue(0, 1, 1, 8'd5, 28'h4000001, 28'h4000000, '{0, 8'd0, 28'h0000010, 0, 0, 6'd7});
        collect("subn");
        retire(28'h0000010);
        issue(0, 1, 1, 8'd127, 28'h4000000, 28'h3FFFFFF, '{0, 8'd101, 28'h4000000, 0, 0, 6'd28});
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1;
        in_valid = 1;
        out_ready = 1;
        @(posedge clk); #1;
        rst = 0;
        in_valid = 0;
        out_ready = 0;
        q.delete();
        chk("midrst_ready", {31'd0, in_ready}, 1);
        chk("midrst_valid", {31'd0, out_valid}, 0);
        chk("midrst_mant", {4'd0, out_mant}, 0);
        hits = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) hits++;
        end
        chk("midrst_no_out", hits, 0);
        chk("midrst_idle", {31'd0, in_ready}, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
